// File: rtl/decrypt_engine_if.sv
// Request/response bundle for the AES-128 decrypt engine: key load, ciphertext in, plaintext out.
interface decrypt_engine_if;
  localparam int unsigned BLK_W = 128;

  logic             set_key;
  logic [BLK_W-1:0] key;
  logic             halt;
  logic             in_valid;
  logic [BLK_W-1:0] state;
  logic             in_ready;
  logic             key_ready;
  logic [BLK_W-1:0] out;
  logic             out_valid;

  modport master (
    output set_key, key, halt, in_valid, state,
    input  in_ready, key_ready, out, out_valid
  );

  modport slave (
    input  set_key, key, halt, in_valid, state,
    output in_ready, key_ready, out, out_valid
  );
endinterface

// File: rtl/decrypt_engine.sv
// Iterative AES-128 inverse cipher: round keys expanded one per cycle, then one
// decryption round per cycle; byte 0 of every block sits in bits [127:120].
module decrypt_engine (
  input  logic             clk,
  input  logic             rst_n,
  decrypt_engine_if.slave  bus
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned NB     = 16;
  localparam int unsigned NUM_RK = 11;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_RK     = CNT_W'(NUM_RK - 1);
  localparam logic [CNT_W-1:0] FIRST_ROUND = CNT_W'(NUM_RK - 2);

  typedef logic [0:NB-1][7:0] blk_t;
  typedef enum logic [1:0] {INIT, KEY_GEN, READY, BUSY} fsm_e;

  // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Row r of the column-major state rotates right by r positions
  function automatic blk_t inv_shift_rows(input blk_t a);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c + r] = a[4*((c - r + 4) % 4) + r];
      end
    end
    return o;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t a);
    blk_t o;
    for (int i = 0; i < NB; i++) begin
      o[i] = inv_sub_byte(a[i]);
    end
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t a);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      o[4*c]     = gf_mul(8'h0e, a[4*c]) ^ gf_mul(8'h0b, a[4*c+1]) ^
                   gf_mul(8'h0d, a[4*c+2]) ^ gf_mul(8'h09, a[4*c+3]);
      o[4*c + 1] = gf_mul(8'h09, a[4*c]) ^ gf_mul(8'h0e, a[4*c+1]) ^
                   gf_mul(8'h0b, a[4*c+2]) ^ gf_mul(8'h0d, a[4*c+3]);
      o[4*c + 2] = gf_mul(8'h0d, a[4*c]) ^ gf_mul(8'h09, a[4*c+1]) ^
                   gf_mul(8'h0e, a[4*c+2]) ^ gf_mul(8'h0b, a[4*c+3]);
      o[4*c + 3] = gf_mul(8'h0b, a[4*c]) ^ gf_mul(8'h0d, a[4*c+1]) ^
                   gf_mul(8'h09, a[4*c+2]) ^ gf_mul(8'h0e, a[4*c+3]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [CNT_W-1:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Next round key from the previous one: four words, first word via RotWord/SubWord/Rcon
  function automatic blk_t expand_key(input blk_t prev, input logic [7:0] rcon);
    logic [BLK_W-1:0] p;
    logic [31:0]      t;
    logic [31:0]      n0, n1, n2, n3;
    p  = prev;
    t  = {sub_byte(p[23:16]), sub_byte(p[15:8]), sub_byte(p[7:0]), sub_byte(p[31:24])}
         ^ {rcon, 24'h000000};
    n0 = p[127:96] ^ t;
    n1 = p[95:64]  ^ n0;
    n2 = p[63:32]  ^ n1;
    n3 = p[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  blk_t             s_q, s_d;
  blk_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             key_ready_q, key_ready_d;
  blk_t             rk_q [NUM_RK];
  logic             rk_we;
  logic [CNT_W-1:0] rk_waddr;
  blk_t             rk_wdata;
  blk_t             round_c;

  // Shared round datapath; cnt_q always stays within 0..10
  assign round_c = inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_q[cnt_q];

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    rk_we       = 1'b0;
    rk_waddr    = '0;
    rk_wdata    = '0;

    case (fsm_q)
      INIT: begin
        if (bus.set_key) begin
          fsm_d    = KEY_GEN;
          cnt_d    = CNT_W'(1);
          rk_we    = 1'b1;
          rk_wdata = bus.key;
        end
      end
      KEY_GEN: begin
        rk_we    = 1'b1;
        rk_waddr = cnt_q;
        rk_wdata = expand_key(rk_q[cnt_q - CNT_W'(1)], rcon_of(cnt_q));
        if (cnt_q == LAST_RK) begin
          fsm_d = READY;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        // Rekey wins over a simultaneously offered ciphertext
        if (bus.set_key) begin
          fsm_d    = KEY_GEN;
          cnt_d    = CNT_W'(1);
          rk_we    = 1'b1;
          rk_wdata = bus.key;
        end else if (bus.in_valid) begin
          fsm_d = BUSY;
          s_d   = bus.state ^ rk_q[LAST_RK];
          cnt_d = FIRST_ROUND;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          s_d   = inv_mix_columns(round_c);
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d       = round_c;
          out_valid_d = 1'b1;
          fsm_d       = READY;
        end
      end
      default: fsm_d = INIT;
    endcase

    // Abort drops any in-flight work; round keys are kept but unusable until rekey
    if (bus.halt) begin
      fsm_d       = INIT;
      cnt_d       = '0;
      s_d         = '0;
      out_d       = out_q;
      out_valid_d = 1'b0;
      rk_we       = 1'b0;
    end

    in_ready_d  = (fsm_d == READY);
    key_ready_d = (fsm_d == READY) || (fsm_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= INIT;
      cnt_q       <= '0;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      key_ready_q <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      key_ready_q <= key_ready_d;
      if (rk_we) rk_q[rk_waddr] <= rk_wdata;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.key_ready = key_ready_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_decrypt_engine.sv
// Scoreboard bench for decrypt_engine: random and FIPS-197 blocks against a
// table-driven AES-128 inverse cipher model.
module tb_decrypt_engine;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst_n;

  decrypt_engine_if bus ();

  decrypt_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [127:0] sb_q[$];
  logic         prev_ov = 1'b0;

  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];
  logic [7:0] gexp [256];
  int         glog [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a};
    return d[15-n -: 8];
  endfunction

  // Build S-boxes from log/antilog tables with generator 3
  task automatic build_tables();
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = p;
      glog[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, s;
      b = (x == 0) ? 8'h00 : gexp[(255 - glog[x]) % 255];
      s = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Reference InvCipher: word key schedule, byte-array state
  function automatic logic [127:0] aes_inv(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  temp;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {sbox[temp[23:16]], sbox[temp[15:8]], sbox[temp[7:0]], sbox[temp[31:24]]}
               ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = st[4*((c-r+4)%4)+r];
      for (int i = 0; i < 16; i++) st[i] = inv_sbox[t[i]] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gm(8'h0e, st[4*c]) ^ gm(8'h0b, st[4*c+1]) ^ gm(8'h0d, st[4*c+2]) ^ gm(8'h09, st[4*c+3]);
          t[4*c+1] = gm(8'h09, st[4*c]) ^ gm(8'h0e, st[4*c+1]) ^ gm(8'h0b, st[4*c+2]) ^ gm(8'h0d, st[4*c+3]);
          t[4*c+2] = gm(8'h0d, st[4*c]) ^ gm(8'h09, st[4*c+1]) ^ gm(8'h0e, st[4*c+2]) ^ gm(8'h0b, st[4*c+3]);
          t[4*c+3] = gm(8'h0b, st[4*c]) ^ gm(8'h0d, st[4*c+1]) ^ gm(8'h09, st[4*c+2]) ^ gm(8'h0e, st[4*c+3]);
        end
        st = t;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected plaintext
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        checks++;
        if (prev_ov) begin
          errors++;
          $display("FAIL out_valid_width actual=2+ cycles expected=1 cycle");
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out actual=%0h expected=no output", bus.out);
        end else begin
          logic [127:0] exp;
          exp = sb_q.pop_front();
          if (bus.out !== exp) begin
            errors++;
            $display("FAIL plaintext actual=%0h expected=%0h", bus.out, exp);
          end
        end
      end
      prev_ov <= bus.out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  task automatic load_key(input logic [127:0] k, input logic with_ct,
                          input logic [127:0] ct, output int lat);
    @(negedge clk);
    bus.set_key  = 1'b1;
    bus.key      = k;
    bus.in_valid = with_ct;
    bus.state    = ct;
    @(posedge clk);
    #1;
    bus.set_key  = 1'b0;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.key_ready) break;
    end
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, output int hs);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.state    = ct;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=in_ready low expected=in_ready high");
      bus.in_valid = 1'b0;
      hs = -1;
    end else begin
      @(posedge clk);
      #1;
      sb_q.push_back(exp);
      hs = cyc;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hs0, hs1, hs2, hi;
    logic [127:0] ct, exp, last_pt, cur_key;

    build_tables();
    bus.set_key  = 1'b0;
    bus.key      = '0;
    bus.halt     = 1'b0;
    bus.in_valid = 1'b0;
    bus.state    = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_key_ready", bus.key_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    rst_n = 1'b1;

    // No key yet: ciphertext must be refused
    bus.in_valid = 1'b1;
    bus.state    = {$urandom, $urandom, $urandom, $urandom};
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready) hi++;
    end
    bus.in_valid = 1'b0;
    check("init_in_ready_cycles", hi, 0);

    load_key(K1, 1'b0, '0, lat);
    check("key_latency_k1", lat, 10);
    check("rk10_k1", dut.rk_q[10], RK10);

    send_block(CT1, PT1, hs0);
    wait_out(lat);
    check("decrypt_latency", lat, 10);
    repeat (3) @(negedge clk);

    load_key(K2, 1'b0, '0, lat);
    check("key_latency_k2", lat, 10);
    ct = {$urandom, $urandom, $urandom, $urandom};
    send_block(CT2, PT2, hs0);
    @(negedge clk);
    check("busy_in_ready", bus.in_ready, 0);
    send_block(CT2, PT2, hs1);
    send_block(ct, aes_inv(K2, ct), hs2);
    check("b2b_gap_1", hs1 - hs0, 11);
    check("b2b_gap_2", hs2 - hs1, 11);
    repeat (15) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      cur_key = {$urandom, $urandom, $urandom, $urandom};
      load_key(cur_key, 1'b0, '0, lat);
      check("key_latency_rand", lat, 10);
      for (int b = 0; b < 3; b++) begin
        ct  = {$urandom, $urandom, $urandom, $urandom};
        exp = aes_inv(cur_key, ct);
        send_block(ct, exp, hs0);
        last_pt = exp;
      end
      repeat (15) @(negedge clk);
    end
    check("drain_random", sb_q.size(), 0);

    // Abort during round 5: nothing emitted, previous plaintext retained
    ct = {$urandom, $urandom, $urandom, $urandom};
    send_block(ct, aes_inv(cur_key, ct), hs0);
    repeat (5) @(negedge clk);
    bus.halt = 1'b1;
    @(posedge clk);
    #1;
    bus.halt = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("halt_key_ready", bus.key_ready, 0);
    check("halt_in_ready", bus.in_ready, 0);
    check("halt_out_held", bus.out, last_pt);
    repeat (15) @(negedge clk);
    check("halt_stays_init", bus.in_ready, 0);

    // Rekey and ciphertext together: rekey wins, no block accepted
    load_key(K2, 1'b0, '0, lat);
    check("key_latency_after_halt", lat, 10);
    load_key(K1, 1'b1, CT2, lat);
    check("rekey_latency", lat, 10);
    send_block(CT1, PT1, hs0);
    repeat (15) @(negedge clk);
    check("drain_rekey", sb_q.size(), 0);

    // Reset in the middle of key expansion
    @(negedge clk);
    bus.set_key = 1'b1;
    bus.key     = K2;
    @(posedge clk);
    #1;
    bus.set_key = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out", bus.out, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_key_ready", bus.key_ready, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_rk10", dut.rk_q[10], 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.state    = CT2;
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.in_ready || bus.key_ready) hi++;
    end
    bus.in_valid = 1'b0;
    check("postrst_not_ready", hi, 0);

    load_key(K2, 1'b0, '0, lat);
    check("key_latency_post_rst", lat, 10);
    send_block(CT2, PT2, hs0);
    repeat (15) @(negedge clk);
    check("drain_final", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
